// File: rtl/decode_exec_reg.sv
// Decode->execute pipeline register with load-use interlock, stall hold and branch flush.
// Two saturating performance counters track inserted bubbles and flushed decode instructions.
module decode_exec_reg #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 64,
  parameter int CTL_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              d_valid,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [CTL_W-1:0]  d_ctl,
  input  logic [DATA_W-1:0] d_srca,
  input  logic [DATA_W-1:0] d_srcb,
  input  logic [4:0]        d_dst,
  input  logic              d_ismem,
  input  logic              bubble_a,
  input  logic              bubble_b,
  input  logic              stall_e,
  input  logic              flush,
  output logic              e_valid,
  output logic [PC_W-1:0]   e_pc,
  output logic [CTL_W-1:0]  e_ctl,
  output logic [DATA_W-1:0] e_srca,
  output logic [DATA_W-1:0] e_srcb,
  output logic [4:0]        e_dst,
  output logic              e_ismem,
  output logic              stall_d,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic [CNT_W-1:0]  cnt_flush
);

  typedef enum logic {RUN, INTERLOCK} state_t;

  state_t state_reg, state_next;

  logic              valid_reg, valid_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [CTL_W-1:0]  ctl_reg, ctl_next;
  logic [DATA_W-1:0] srca_reg, srca_next;
  logic [DATA_W-1:0] srcb_reg, srcb_next;
  logic [4:0]        dst_reg, dst_next;
  logic              ismem_reg, ismem_next;

  // index 0: interlock bubbles, index 1: flushes
  logic [1:0]        cnt_inc;
  logic [CNT_W-1:0]  cnt_reg [2];

  logic hazard;

  assign hazard  = d_valid & (bubble_a | bubble_b);
  assign stall_d = resetn & (stall_e | (hazard & ~flush));

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    pc_next    = pc_reg;
    ctl_next   = ctl_reg;
    srca_next  = srca_reg;
    srcb_next  = srcb_reg;
    dst_next   = dst_reg;
    ismem_next = ismem_reg;
    cnt_inc    = 2'b00;
    if (!stall_e) begin
      // NOP fields first; only a clean advance of a valid instruction overwrites them
      valid_next = 1'b0;
      pc_next    = '0;
      ctl_next   = '0;
      srca_next  = '0;
      srcb_next  = '0;
      dst_next   = '0;
      ismem_next = 1'b0;
      state_next = RUN;
      if (flush) begin
        cnt_inc[1] = d_valid;
      end else if (hazard) begin
        cnt_inc[0] = 1'b1;
        state_next = INTERLOCK;
      end else if (d_valid) begin
        valid_next = 1'b1;
        pc_next    = d_pc;
        ctl_next   = d_ctl;
        srca_next  = d_srca;
        srcb_next  = d_srcb;
        dst_next   = d_dst;
        ismem_next = d_ismem;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= RUN;
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      ctl_reg   <= '0;
      srca_reg  <= '0;
      srcb_reg  <= '0;
      dst_reg   <= '0;
      ismem_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      pc_reg    <= pc_next;
      ctl_reg   <= ctl_next;
      srca_reg  <= srca_next;
      srcb_reg  <= srcb_next;
      dst_reg   <= dst_next;
      ismem_reg <= ismem_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign e_valid    = valid_reg;
  assign e_pc       = pc_reg;
  assign e_ctl      = ctl_reg;
  assign e_srca     = srca_reg;
  assign e_srcb     = srcb_reg;
  assign e_dst      = dst_reg;
  assign e_ismem    = ismem_reg;
  assign cnt_bubble = cnt_reg[0];
  assign cnt_flush  = cnt_reg[1];

  // After one bubble the load sits in memory and must forward; a second hazard means a broken forward path
  a_no_rehazard: assert property (@(posedge clk) disable iff (!resetn)
    (state_reg == INTERLOCK && !stall_e && !flush) |-> !hazard);

endmodule

// File: tb/tb_decode_exec_reg.sv
// Scoreboard bench for decode_exec_reg: a behavioural model pushes expected E-stage state per
// cycle, popped and compared one edge later. Narrow counters make saturation reachable.
module tb_decode_exec_reg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        d_valid = 1'b0;
  logic [63:0] d_pc = '0;
  logic [31:0] d_ctl = '0;
  logic [63:0] d_srca = '0;
  logic [63:0] d_srcb = '0;
  logic [4:0]  d_dst = '0;
  logic        d_ismem = 1'b0;
  logic        bubble_a = 1'b0;
  logic        bubble_b = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush = 1'b0;
  logic        e_valid;
  logic [63:0] e_pc;
  logic [31:0] e_ctl;
  logic [63:0] e_srca;
  logic [63:0] e_srcb;
  logic [4:0]  e_dst;
  logic        e_ismem;
  logic        stall_d;
  logic [CNT_W-1:0] cnt_bubble;
  logic [CNT_W-1:0] cnt_flush;

  decode_exec_reg #(.PC_W(64), .DATA_W(64), .CTL_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .d_valid(d_valid), .d_pc(d_pc), .d_ctl(d_ctl), .d_srca(d_srca), .d_srcb(d_srcb),
    .d_dst(d_dst), .d_ismem(d_ismem), .bubble_a(bubble_a), .bubble_b(bubble_b),
    .stall_e(stall_e), .flush(flush),
    .e_valid(e_valid), .e_pc(e_pc), .e_ctl(e_ctl), .e_srca(e_srca), .e_srcb(e_srcb),
    .e_dst(e_dst), .e_ismem(e_ismem), .stall_d(stall_d),
    .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid;
    logic [63:0]      pc;
    logic [31:0]      ctl;
    logic [63:0]      srca;
    logic [63:0]      srcb;
    logic [4:0]       dst;
    logic             ismem;
    logic [CNT_W-1:0] cb;
    logic [CNT_W-1:0] cf;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  logic m_intl;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m = '0;
    m_intl = 1'b0;
    exp_q.delete();
  endtask

  task automatic compare(input string pfx, input exp_t e);
    check({pfx, ".e_valid"}, 64'(e_valid), 64'(e.valid));
    check({pfx, ".e_pc"}, e_pc, e.pc);
    check({pfx, ".e_ctl"}, 64'(e_ctl), 64'(e.ctl));
    check({pfx, ".e_srca"}, e_srca, e.srca);
    check({pfx, ".e_srcb"}, e_srcb, e.srcb);
    check({pfx, ".e_dst"}, 64'(e_dst), 64'(e.dst));
    check({pfx, ".e_ismem"}, 64'(e_ismem), 64'(e.ismem));
    check({pfx, ".cnt_bubble"}, 64'(cnt_bubble), 64'(e.cb));
    check({pfx, ".cnt_flush"}, 64'(cnt_flush), 64'(e.cf));
  endtask

  // Inputs already driven after a falling edge; predict, clock, compare.
  task automatic step(input string tag);
    logic hz;
    exp_t e;
    #1;
    hz = d_valid & (bubble_a | bubble_b);
    check({tag, ".stall_d"}, 64'(stall_d), 64'(stall_e | (hz & ~flush)));
    if (!stall_e) begin
      if (flush) begin
        if (d_valid && m.cf != CMAX) m.cf = m.cf + 1'b1;
        m.valid = 0; m.pc = 0; m.ctl = 0; m.srca = 0; m.srcb = 0; m.dst = 0; m.ismem = 0;
        m_intl = 1'b0;
      end else if (hz) begin
        if (m.cb != CMAX) m.cb = m.cb + 1'b1;
        m.valid = 0; m.pc = 0; m.ctl = 0; m.srca = 0; m.srcb = 0; m.dst = 0; m.ismem = 0;
        m_intl = 1'b1;
      end else if (d_valid) begin
        m.valid = 1; m.pc = d_pc; m.ctl = d_ctl; m.srca = d_srca; m.srcb = d_srcb;
        m.dst = d_dst; m.ismem = d_ismem;
        m_intl = 1'b0;
      end else begin
        m.valid = 0; m.pc = 0; m.ctl = 0; m.srca = 0; m.srcb = 0; m.dst = 0; m.ismem = 0;
        m_intl = 1'b0;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(tag, e);
    $display("txn %-10s e_valid=%0b e_pc=%h e_dst=%0d stall_e=%0b flush=%0b cb=%0d cf=%0d",
             tag, e_valid, e_pc, e_dst, stall_e, flush, cnt_bubble, cnt_flush);
    @(negedge clk);
  endtask

  task automatic drive(input string tag, input logic v, input logic [63:0] pc,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst,
                       input logic ism, input logic ba, input logic bb,
                       input logic se, input logic fl);
    d_valid = v; d_pc = pc; d_ctl = $urandom; d_srca = a; d_srcb = b; d_dst = dst;
    d_ismem = ism; bubble_a = ba; bubble_b = bb; stall_e = se; flush = fl;
    step(tag);
  endtask

  // Reset held with live decode inputs: everything must read as idle.
  task automatic do_reset();
    resetn = 1'b0;
    d_valid = 1'b1; bubble_a = 1'b1; bubble_b = 1'b0; stall_e = 1'b0; flush = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst.e_valid", 64'(e_valid), 64'd0);
      check("rst.stall_d", 64'(stall_d), 64'd0);
      check("rst.cnt_bubble", 64'(cnt_bubble), 64'd0);
      check("rst.cnt_flush", 64'(cnt_flush), 64'd0);
      $display("txn reset      e_valid=%0b stall_d=%0b", e_valid, stall_d);
    end
    @(negedge clk);
    d_valid = 1'b0; bubble_a = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Pass-through, then load-use interlock
    drive("pass", 1, 64'h8000_0000, 64'd5, 64'd9, 5'd3, 0, 0, 0, 0, 0);
    check("pass.e_pc_lit", e_pc, 64'h8000_0000);
    drive("ld", 1, 64'h8000_0004, 64'd100, 64'd8, 5'd5, 1, 0, 0, 0, 0);
    drive("ldu_bub", 1, 64'h8000_0008, 64'd0, 64'd7, 5'd6, 0, 1, 0, 0, 0);
    check("ldu.cnt_bubble_lit", 64'(cnt_bubble), 64'd1);
    drive("ldu_add", 1, 64'h8000_0008, 64'h1234, 64'd7, 5'd6, 0, 0, 0, 0, 0);
    drive("idle", 0, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 0);

    // Flush and hazard in the same cycle
    do_reset();
    drive("fl_hz", 1, 64'h100, 64'd1, 64'd2, 5'd4, 0, 1, 1, 0, 1);
    check("fl_hz.cnt_flush_lit", 64'(cnt_flush), 64'd1);
    drive("fl_novld", 0, 64'h104, 64'd1, 64'd2, 5'd4, 0, 0, 0, 0, 1);

    // Stall held over a pending flush, then flush applied once
    do_reset();
    drive("st_pre", 1, 64'h200, 64'hAA, 64'hBB, 5'd7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("st_hold", 1, 64'h204, 64'h11, 64'h22, 5'd8, 0, 0, 0, 1, 1);
    drive("st_rel", 1, 64'h204, 64'h11, 64'h22, 5'd8, 0, 0, 0, 0, 1);
    check("st_rel.cnt_flush_lit", 64'(cnt_flush), 64'd1);
    drive("st_hz", 1, 64'h208, 64'h0, 64'h0, 5'd9, 0, 0, 1, 1, 0);
    drive("st_hz2", 1, 64'h208, 64'h0, 64'h0, 5'd9, 0, 0, 1, 0, 0);
    drive("st_go", 1, 64'h208, 64'h5, 64'h6, 5'd9, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle
    drive("pre_ar", 1, 64'h300, 64'h77, 64'h88, 5'd10, 1, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check("async.e_valid", 64'(e_valid), 64'd0);
    check("async.e_pc", e_pc, 64'd0);
    check("async.e_dst", 64'(e_dst), 64'd0);
    check("async.cnt_bubble", 64'(cnt_bubble), 64'd0);
    $display("txn async_rst  e_valid=%0b e_pc=%h", e_valid, e_pc);
    @(negedge clk);
    do_reset();

    // Bubble counter saturation
    for (int i = 0; i < int'(CMAX) + 2; i++) begin
      drive("sat_hz", 1, 64'h400, 64'h0, 64'h0, 5'd1, 0, 1, 0, 0, 0);
      drive("sat_go", 1, 64'h400, 64'h3, 64'h4, 5'd1, 0, 0, 0, 0, 0);
    end
    check("sat.cnt_bubble_lit", 64'(cnt_bubble), 64'(CMAX));

    // Random traffic that respects the one-bubble interlock protocol
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic se, fl, ba, bb;
      se = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 7) == 0);
      ba = ($urandom_range(0, 4) == 0);
      bb = ($urandom_range(0, 4) == 0);
      if (m_intl && !se && !fl) begin ba = 0; bb = 0; end
      drive("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
            1'($urandom), ba, bb, se, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
